// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the shared RAM port between cache requesters. Writes outrank
// reads, round-robin within each class, and age counters force long waiters through.
module mem_bus_arbiter #(
    parameter int REQS = 4,
    parameter int MAX_WAIT = 15,
    localparam int IW = $clog2(REQS),
    localparam int AW = $clog2(MAX_WAIT + 1)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [REQS-1:0] req,
    input  logic [REQS-1:0] req_wr,
    input  logic [REQS-1:0] req_len,
    input  logic            ram_access,
    output logic [REQS-1:0] grant,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_id,
    output logic            beat,
    output logic            done,
    output logic            abort
);
    typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;
    state_t state, state_n;
    logic [IW-1:0] rr, rr_n, id_n, win, next_id, old_id;
    logic old, len, len_n, beat_n, done_n, abort_n;
    logic [AW-1:0] age [REQS];

    function automatic logic [IW-1:0] rr_pick(input logic [REQS-1:0] m, input logic [IW-1:0] p);
        logic [IW-1:0] j;
        rr_pick = '0;
        for (int k = REQS - 1; k >= 0; k--) begin
            j = IW'((int'(p) + k) % REQS);
            if (m[j]) rr_pick = j;
        end
    endfunction

    // Starving requesters beat everything; lowest index among them wins.
    always_comb begin
        old = 1'b0;
        old_id = '0;
        for (int i = REQS - 1; i >= 0; i--)
            if (req[i] && age[i] >= AW'(MAX_WAIT)) begin
                old = 1'b1;
                old_id = IW'(i);
            end
        win = old ? old_id : |(req & req_wr) ? rr_pick(req & req_wr, rr) : rr_pick(req, rr);
    end

    assign next_id = (grant_id == IW'(REQS - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_n = state;
        id_n = grant_id;
        len_n = len;
        beat_n = beat;
        rr_n = rr;
        done_n = 1'b0;
        abort_n = 1'b0;
        case (state)
            IDLE: if (|req) begin
                state_n = BUSY;
                id_n = win;
                len_n = req_len[win];
                beat_n = 1'b0;
            end
            // A dropped request wins over a coincident final beat: abort, never done.
            BUSY: if (!req[grant_id] || (ram_access && beat == len)) begin
                state_n = TURN;
                abort_n = !req[grant_id];
                done_n = req[grant_id];
                beat_n = 1'b0;
                rr_n = next_id;
            end else if (ram_access) beat_n = 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            state <= IDLE;
            rr <= '0;
            len <= 1'b0;
            grant <= '0;
            grant_valid <= 1'b0;
            grant_id <= '0;
            beat <= 1'b0;
            done <= 1'b0;
            abort <= 1'b0;
        end else begin
            state <= state_n;
            rr <= rr_n;
            len <= len_n;
            grant <= (state_n == BUSY) ? REQS'(1) << id_n : '0;
            grant_valid <= state_n == BUSY;
            grant_id <= (state_n == BUSY) ? id_n : '0;
            beat <= beat_n;
            done <= done_n;
            abort <= abort_n;
        end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST)
            for (int i = 0; i < REQS; i++) age[i] <= '0;
        else
            for (int i = 0; i < REQS; i++)
                age[i] <= (!req[i] || grant[i]) ? '0 : (age[i] == AW'(MAX_WAIT)) ? age[i] : age[i] + 1'b1;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed burst/priority/starvation scenarios plus random traffic,
// all checked cycle by cycle against a behavioural arbitration model.
module tb_mem_bus_arbiter;
    localparam int REQS = 4;
    localparam int MAX_WAIT = 15;
    logic CLK = 1'b0, nRST = 1'b0;
    logic [3:0] req = '0, req_wr = '0, req_len = '0;
    logic ram_access = 1'b0;
    logic [3:0] grant;
    logic grant_valid, beat, done, abort;
    logic [1:0] grant_id;
    int tests = 0, fails = 0;
    int seq;
    logic [1:0] owner_q = '0;

    mem_bus_arbiter #(.REQS(REQS), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .req_wr(req_wr), .req_len(req_len),
        .ram_access(ram_access), .grant(grant), .grant_valid(grant_valid),
        .grant_id(grant_id), .beat(beat), .done(done), .abort(abort)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {grant, grant_valid, grant_id, beat, done, abort};
    endfunction

    function automatic logic [9:0] ex(input logic [3:0] g, input logic [1:0] id, input logic b, input logic d, input logic a);
        return {g, |g, id, b, d, a};
    endfunction

    // Behavioural model: owner index (-1 = none), turnaround flag, wait ages as plain ints.
    int m_owner = -1, m_len = 0, m_beat = 0, m_rr = 0;
    bit m_turn = 0, m_done = 0, m_abort = 0;
    int m_age [REQS];

    function automatic int pick();
        for (int i = 0; i < REQS; i++) if (req[i] && m_age[i] >= MAX_WAIT) return i;
        for (int k = 0; k < REQS; k++) if (req[(m_rr + k) % REQS] && req_wr[(m_rr + k) % REQS]) return (m_rr + k) % REQS;
        for (int k = 0; k < REQS; k++) if (req[(m_rr + k) % REQS]) return (m_rr + k) % REQS;
        return -1;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        int na [REQS];
        int w;
        if (!nRST) begin
            m_owner = -1; m_turn = 0; m_beat = 0; m_len = 0; m_rr = 0; m_done = 0; m_abort = 0;
            for (int i = 0; i < REQS; i++) m_age[i] = 0;
        end else begin
            for (int i = 0; i < REQS; i++)
                na[i] = (!req[i] || m_owner == i) ? 0 : (m_age[i] >= MAX_WAIT ? MAX_WAIT : m_age[i] + 1);
            m_done = 0;
            m_abort = 0;
            if (m_turn) m_turn = 0;
            else if (m_owner < 0) begin
                w = pick();
                if (w >= 0) begin m_owner = w; m_len = int'(req_len[w]); m_beat = 0; end
            end else if (!req[m_owner] || (ram_access && m_beat == m_len)) begin
                m_abort = !req[m_owner];
                m_done = req[m_owner];
                m_rr = (m_owner + 1) % REQS;
                m_owner = -1;
                m_turn = 1;
                m_beat = 0;
            end else if (ram_access) m_beat = m_beat + 1;
            m_age = na;
        end
    end

    always @(negedge CLK) begin
        logic [3:0] eg;
        logic [1:0] eid;
        if (nRST) begin
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
            eid = (m_owner >= 0) ? 2'(m_owner) : 2'b0;
            chk("model", {22'b0, outs()}, {22'b0, ex(eg, eid, m_beat[0], m_done, m_abort)});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        req = '0; req_wr = '0; req_len = '0; ram_access = 1'b0;
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    // Records each new grant's id as a hex digit of seq; optionally retires finished requesters.
    task automatic collect(input int n, input bit clr);
        int cnt = 0;
        bit prev = 0;
        logic [1:0] last = '0;
        seq = 0;
        for (int c = 0; c < 200 && cnt < n; c++) begin
            tick();
            if (grant_valid && !prev) begin
                seq = seq * 16 + int'(grant_id);
                last = grant_id;
                cnt++;
            end
            if (clr && (done || abort)) req[last] = 1'b0;
            prev = grant_valid;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("reset outputs", {22'b0, outs()}, 32'h0);
        req = 4'b0001;
        tick();
        chk("T1 grant", {22'b0, outs()}, {22'b0, ex(4'b0001, 2'd0, 0, 0, 0)});
        tick();
        tick();
        chk("T1 hold", {22'b0, outs()}, {22'b0, ex(4'b0001, 2'd0, 0, 0, 0)});
        ram_access = 1'b1;
        tick();
        chk("T1 done", {22'b0, outs()}, {22'b0, ex(4'b0000, 2'd0, 0, 1, 0)});
        ram_access = 1'b0;
        req = '0;
        tick();
        chk("T1 after", {22'b0, outs()}, 32'h0);

        do_reset();
        req = 4'b1111;
        ram_access = 1'b1;
        collect(5, 0);
        chk("T2 order", seq, 32'h01230);

        do_reset();
        req = 4'b0011;
        req_wr = 4'b0010;
        ram_access = 1'b1;
        collect(2, 1);
        chk("T3 order", seq, 32'h10);

        do_reset();
        req = 4'b1011;
        req_wr = 4'b1010;
        ram_access = 1'b1;
        collect(6, 0);
        chk("T4 order", seq, 32'h131310);

        do_reset();
        req = 4'b0001;
        req_len = 4'b0001;
        tick();
        chk("T5 beat0", {22'b0, outs()}, {22'b0, ex(4'b0001, 2'd0, 0, 0, 0)});
        ram_access = 1'b1;
        tick();
        chk("T5 beat1", {22'b0, outs()}, {22'b0, ex(4'b0001, 2'd0, 1, 0, 0)});
        ram_access = 1'b0;
        tick();
        chk("T5 wait", {22'b0, outs()}, {22'b0, ex(4'b0001, 2'd0, 1, 0, 0)});
        ram_access = 1'b1;
        tick();
        chk("T5 done", {22'b0, outs()}, {22'b0, ex(4'b0000, 2'd0, 0, 1, 0)});

        do_reset();
        req = 4'b0001;
        req_len = 4'b0001;
        tick();
        ram_access = 1'b1;
        tick();
        ram_access = 1'b0;
        req = '0;
        tick();
        chk("T6 abort", {22'b0, outs()}, {22'b0, ex(4'b0000, 2'd0, 0, 0, 1)});
        tick();
        chk("T6 turn", {22'b0, outs()}, 32'h0);
        req = 4'b0100;
        tick();
        chk("T6 grant2", {22'b0, outs()}, {22'b0, ex(4'b0100, 2'd2, 0, 0, 0)});
        #2;
        nRST = 1'b0;
        #1;
        chk("T6 async reset", {22'b0, outs()}, 32'h0);
        req = '0;
        tick();
        nRST = 1'b1;

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            if (grant_valid) owner_q = grant_id;
            if (done) req[owner_q] = 1'b0;
            for (int i = 0; i < REQS; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_wr[i] = 1'($urandom_range(0, 1));
                        req_len[i] = 1'($urandom_range(0, 1));
                    end
                end else begin
                    if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
                    if ($urandom_range(0, 7) == 0) req_wr[i] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) req_len[i] = 1'($urandom_range(0, 1));
                end
            end
            ram_access = 1'($urandom_range(0, 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
